// File: rtl/uart_fifo_bridge.sv
// Byte FIFOs between system logic and a UART core's write/busy and ready/ack handshakes.
// RX byte reaches rx_data_o 2 cycles after ready rises; full TX ignores pushes, full RX acks and drops (sticky overrun).

module uart_fifo_bridge_fifo #(
  parameter int AW = 4
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [7:0]    mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [AW:0]   count_n;

  // A pop frees the slot a same-cycle push needs, so full only blocks a lone push.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    count_n = count;
    if (do_push && !do_pop)
      count_n = count + 1'b1;
    else if (do_pop && !do_push)
      count_n = count - 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= count_n[AW];
      empty <= (count_n == '0);
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
endmodule

module uart_fifo_bridge #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [7:0]            tx_data_i,
  input  logic                  tx_push_i,
  output logic                  tx_full_o,
  output logic [DEPTH_LOG2:0]   tx_count_o,
  output logic [7:0]            rx_data_o,
  input  logic                  rx_pop_i,
  output logic                  rx_empty_o,
  output logic [DEPTH_LOG2:0]   rx_count_o,
  output logic                  rx_overrun_o,
  input  logic                  rx_overrun_clear_i,
  output logic [7:0]            uart_data_o,
  output logic                  uart_write_o,
  input  logic                  uart_write_busy_i,
  input  logic [7:0]            uart_data_i,
  input  logic                  uart_read_ready_i,
  output logic                  uart_ack_o
);
  typedef enum logic [1:0] {TX_IDLE, TX_WRITE, TX_WAIT_BUSY, TX_WAIT_IDLE} tx_state_t;
  typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;

  tx_state_t tx_state;
  rx_state_t rx_state;

  logic       tx_empty;
  logic [7:0] tx_head;
  logic       tx_pop;
  logic       rx_full;
  logic [7:0] rx_head;
  logic [7:0] rx_byte;
  logic       rx_push_q;
  logic       rx_take;
  logic       rx_drop;

  assign tx_pop = (tx_state == TX_IDLE) && !tx_empty && !uart_write_busy_i;

  uart_fifo_bridge_fifo #(.AW(DEPTH_LOG2)) u_tx_fifo (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .push      (tx_push_i),
    .push_data (tx_data_i),
    .pop       (tx_pop),
    .head      (tx_head),
    .count     (tx_count_o),
    .full      (tx_full_o),
    .empty     (tx_empty)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      tx_state     <= TX_IDLE;
      uart_write_o <= 1'b0;
      uart_data_o  <= 8'h00;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            uart_data_o  <= tx_head;
            uart_write_o <= 1'b1;
            tx_state     <= TX_WRITE;
          end
        end
        TX_WRITE: begin
          uart_write_o <= 1'b0;
          tx_state     <= TX_WAIT_BUSY;
        end
        TX_WAIT_BUSY: if (uart_write_busy_i) tx_state <= TX_WAIT_IDLE;
        TX_WAIT_IDLE: if (!uart_write_busy_i) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Space is decided when the byte is seen; the push lands one cycle later, and
  // no other RX push can intervene, so the reserved slot is still free then.
  assign rx_take = (rx_state == RX_IDLE) && uart_read_ready_i;
  assign rx_drop = rx_take && rx_full && !rx_pop_i;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rx_state     <= RX_IDLE;
      uart_ack_o   <= 1'b0;
      rx_byte      <= 8'h00;
      rx_push_q    <= 1'b0;
      rx_overrun_o <= 1'b0;
    end else begin
      rx_push_q <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_take) begin
            rx_byte    <= uart_data_i;
            rx_push_q  <= !rx_drop;
            uart_ack_o <= 1'b1;
            rx_state   <= RX_ACK;
          end
        end
        RX_ACK: begin
          if (!uart_read_ready_i) begin
            uart_ack_o <= 1'b0;
            rx_state   <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
      if (rx_drop)
        rx_overrun_o <= 1'b1;
      else if (rx_overrun_clear_i)
        rx_overrun_o <= 1'b0;
    end
  end

  uart_fifo_bridge_fifo #(.AW(DEPTH_LOG2)) u_rx_fifo (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .push      (rx_push_q),
    .push_data (rx_byte),
    .pop       (rx_pop_i),
    .head      (rx_head),
    .count     (rx_count_o),
    .full      (rx_full),
    .empty     (rx_empty_o)
  );

  assign rx_data_o = rx_empty_o ? 8'h00 : rx_head;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Scoreboard bench for uart_fifo_bridge with a simple busy-period core model.
module tb_uart_fifo_bridge;
  logic       clk = 1'b0;
  logic       reset_i = 1'b0;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_push_i = 1'b0;
  logic       tx_full_o;
  logic [4:0] tx_count_o;
  logic [7:0] rx_data_o;
  logic       rx_pop_i = 1'b0;
  logic       rx_empty_o;
  logic [4:0] rx_count_o;
  logic       rx_overrun_o;
  logic       rx_overrun_clear_i = 1'b0;
  logic [7:0] uart_data_o;
  logic       uart_write_o;
  logic       uart_write_busy_i;
  logic [7:0] uart_data_i = 8'h00;
  logic       uart_read_ready_i = 1'b0;
  logic       uart_ack_o;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt = 0;
  logic force_busy = 1'b0;
  int write_pulses = 0;
  logic prev_write = 1'b0;
  logic [7:0] last_tx = 8'h00;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
    .clock_i(clk), .reset_i(reset_i),
    .tx_data_i(tx_data_i), .tx_push_i(tx_push_i), .tx_full_o(tx_full_o), .tx_count_o(tx_count_o),
    .rx_data_o(rx_data_o), .rx_pop_i(rx_pop_i), .rx_empty_o(rx_empty_o), .rx_count_o(rx_count_o),
    .rx_overrun_o(rx_overrun_o), .rx_overrun_clear_i(rx_overrun_clear_i),
    .uart_data_o(uart_data_o), .uart_write_o(uart_write_o), .uart_write_busy_i(uart_write_busy_i),
    .uart_data_i(uart_data_i), .uart_read_ready_i(uart_read_ready_i), .uart_ack_o(uart_ack_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Core model: busy rises the cycle after a write strobe and lasts 20 cycles.
  always @(posedge clk) begin
    if (reset_i) busy_cnt <= 0;
    else if (uart_write_o) busy_cnt <= 20;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_write_busy_i = force_busy || (busy_cnt != 0);

  always @(negedge clk) begin
    if (!reset_i) begin
      if (uart_write_o) begin
        write_pulses++;
        check("write_gap", prev_write, 1'b0);
        check("tx_expected_pending", tx_q.size() != 0, 1'b1);
        if (tx_q.size() != 0) begin
          last_tx = tx_q.pop_front();
          check("tx_data", uart_data_o, last_tx);
        end
      end
      if (busy_cnt == 1) check("tx_data_stable", uart_data_o, last_tx);
    end
    prev_write = uart_write_o;
  end

  task automatic push_tx(input logic [7:0] b);
    tx_data_i = b;
    tx_push_i = 1'b1;
    tick();
    tx_push_i = 1'b0;
  endtask

  task automatic wait_tx_done(input int limit);
    int n = 0;
    while (!(tx_q.size() == 0 && busy_cnt == 0 && tx_count_o == 0 && !uart_write_o) && n < limit) begin
      tick();
      n++;
    end
    check("tx_drain_in_time", n < limit, 1'b1);
    tick();
    tick();
  endtask

  task automatic pop_rx();
    check("rx_head", rx_data_o, rx_q[0]);
    void'(rx_q.pop_front());
    rx_pop_i = 1'b1;
    tick();
    rx_pop_i = 1'b0;
  endtask

  // Core presents a byte for 'hold' cycles; optionally pops the RX head in the first one.
  task automatic rx_present(input logic [7:0] b, input int hold, input bit was_empty, input bit pop_first);
    if (pop_first) begin
      check("rx_head_before_swap", rx_data_o, rx_q[0]);
      void'(rx_q.pop_front());
      rx_pop_i = 1'b1;
    end
    uart_data_i = b;
    uart_read_ready_i = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      tick();
      rx_pop_i = 1'b0;
      check("rx_ack_high", uart_ack_o, 1'b1);
      if (was_empty && k == 1) check("rx_empty_at_1", rx_empty_o, 1'b1);
      if (was_empty && k == 2) begin
        check("rx_empty_at_2", rx_empty_o, 1'b0);
        check("rx_data_at_2", rx_data_o, b);
      end
    end
    uart_read_ready_i = 1'b0;
    tick();
    check("rx_ack_low", uart_ack_o, 1'b0);
  endtask

  initial begin
    int base;
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    check("rst_tx_count", tx_count_o, 0);
    check("rst_rx_count", rx_count_o, 0);
    check("rst_tx_full", tx_full_o, 0);
    check("rst_rx_empty", rx_empty_o, 1);
    check("rst_overrun", rx_overrun_o, 0);
    check("rst_write", uart_write_o, 0);
    check("rst_ack", uart_ack_o, 0);
    check("rst_uart_data", uart_data_o, 0);
    check("rst_rx_data", rx_data_o, 0);

    // Three bytes through the transmitter
    base = write_pulses;
    foreach (tx_q[i]) ;
    tx_q.push_back(8'h55); push_tx(8'h55);
    tx_q.push_back(8'hA3); push_tx(8'hA3);
    tx_q.push_back(8'h0F); push_tx(8'h0F);
    wait_tx_done(500);
    check("tx3_pulses", write_pulses - base, 3);
    check("tx3_count", tx_count_o, 0);

    // Fill TX past capacity while the core is busy
    force_busy = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) tx_q.push_back(8'h10 + 8'(i));
      push_tx(8'h10 + 8'(i));
      if (i == 15) check("tx_full_at_16", tx_full_o, 1'b1);
    end
    check("tx_count_after_17", tx_count_o, 16);
    check("tx_full_after_17", tx_full_o, 1'b1);
    base = write_pulses;
    force_busy = 1'b0;
    wait_tx_done(2000);
    check("tx16_pulses", write_pulses - base, 16);
    check("tx_full_drained", tx_full_o, 1'b0);

    // Single received byte with ready held 5 cycles
    rx_q.push_back(8'h3C);
    rx_present(8'h3C, 5, 1'b1, 1'b0);
    check("rx_one_count", rx_count_o, 1);
    check("rx_one_data", rx_data_o, 8'h3C);

    // Fill RX, then overrun
    for (int i = 0; i < 15; i++) begin
      rx_q.push_back(8'h40 + 8'(i));
      rx_present(8'h40 + 8'(i), 2, 1'b0, 1'b0);
    end
    check("rx_full_count", rx_count_o, 16);
    check("rx_overrun_before", rx_overrun_o, 1'b0);
    rx_present(8'h99, 2, 1'b0, 1'b0);
    check("rx_overrun_set", rx_overrun_o, 1'b1);
    check("rx_count_after_drop", rx_count_o, 16);
    check("rx_head_after_drop", rx_data_o, 8'h3C);
    rx_overrun_clear_i = 1'b1;
    tick();
    rx_overrun_clear_i = 1'b0;
    check("rx_overrun_cleared", rx_overrun_o, 1'b0);

    // Full RX: pop and receive in the same cycle, then drain across the wrap
    rx_q.push_back(8'h77);
    rx_present(8'h77, 2, 1'b0, 1'b1);
    check("rx_swap_count", rx_count_o, 16);
    check("rx_swap_overrun", rx_overrun_o, 1'b0);
    for (int i = 0; i < 16; i++) pop_rx();
    check("rx_drained_empty", rx_empty_o, 1'b1);
    check("rx_drained_count", rx_count_o, 0);

    // Reset while the transmitter waits out a busy period with 3 bytes queued
    for (int i = 0; i < 4; i++) begin
      tx_q.push_back(8'hA0 + 8'(i));
      push_tx(8'hA0 + 8'(i));
    end
    begin
      int n = 0;
      while (busy_cnt != 10 && n < 200) begin
        tick();
        n++;
      end
      check("busy_mid_reached", n < 200, 1'b1);
    end
    check("tx_queued_3", tx_count_o, 3);
    reset_i = 1'b1;
    tx_q.delete();
    tick();
    check("rst_mid_write", uart_write_o, 1'b0);
    check("rst_mid_tx_count", tx_count_o, 0);
    check("rst_mid_uart_data", uart_data_o, 0);
    reset_i = 1'b0;
    tick();
    base = write_pulses;
    tx_q.push_back(8'hC5);
    push_tx(8'hC5);
    wait_tx_done(500);
    check("post_reset_pulses", write_pulses - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
- Client-side end of the UART core's data-bus interface: it drives the transmitter's data/write/busy handshake and drains the receiver's data/ready/ack handshake.
- Buffers both directions in synchronous FIFOs, so system logic pushes and pops bytes without tracking byte timing.
- Sits between system logic and the UART transceiver, one instance per UART.

Parameters:
- DEPTH_LOG2, 4, log2 of each FIFO's depth (TX and RX each hold 2^DEPTH_LOG2 bytes); minimum 1.

Ports:
- clock_i  input  1  clock, rising edge.
- reset_i  input  1  synchronous reset, active-high.
- tx_data_i  input  8  byte to queue for transmission.
- tx_push_i  input  1  push tx_data_i into the TX FIFO this cycle.
- tx_full_o  output  1  TX FIFO full.
- tx_count_o  output  DEPTH_LOG2+1  TX FIFO occupancy.
- rx_data_o  output  8  head of the RX FIFO (first-word fall-through).
- rx_pop_i  input  1  pop the RX head this cycle.
- rx_empty_o  output  1  RX FIFO empty.
- rx_count_o  output  DEPTH_LOG2+1  RX FIFO occupancy.
- rx_overrun_o  output  1  sticky: a received byte was dropped because the RX FIFO was full.
- rx_overrun_clear_i  input  1  clears rx_overrun_o.
- uart_data_o  output  8  to the core's transmit data input.
- uart_write_o  output  1  to the core's write input.
- uart_write_busy_i  input  1  from the core's transmit-busy output.
- uart_data_i  input  8  from the core's receive data output.
- uart_read_ready_i  input  1  from the core's read-ready output.
- uart_ack_o  output  1  to the core's acknowledge input.

Behaviour:
- Reset values:
  - Both FIFOs empty; tx_count_o=0, rx_count_o=0.
  - tx_full_o=0, rx_empty_o=1, rx_overrun_o=0.
  - uart_write_o=0, uart_ack_o=0, uart_data_o=0, rx_data_o=0.
  - Both FSMs in IDLE.
- Reset mid-byte: FSMs go to IDLE and all queued bytes are discarded. The core is reset separately.
- FIFO rules, both FIFOs:
  - Circular buffer with DEPTH_LOG2-bit pointers; pointers wrap modulo depth.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Push when full with no pop: ignored, no state change.
  - Pop when empty: ignored.
  - Simultaneous push and pop on a non-empty FIFO: count unchanged, data order preserved.
  - Pushing into an empty RX FIFO shows the byte on rx_data_o the next cycle.
- TX FSM states are IDLE, WRITE, WAIT_BUSY, WAIT_IDLE:
  - IDLE: if the TX FIFO is non-empty and uart_write_busy_i=0, pop the head into uart_data_o and go to WRITE.
  - WRITE: uart_write_o=1 for exactly this one cycle; go to WAIT_BUSY.
  - WAIT_BUSY: uart_write_o=0; stay until uart_write_busy_i=1, then go to WAIT_IDLE.
  - WAIT_IDLE: stay until uart_write_busy_i=0, then go to IDLE.
  - uart_data_o holds the popped byte stable from WRITE through WAIT_IDLE.
  - uart_write_o is never high on two consecutive cycles. This satisfies the core's requirement that write go low after each write.
  - Throughput: at most one byte per core busy period plus 2 cycles.
- RX FSM states are IDLE, ACK:
  - IDLE: on uart_read_ready_i=1, capture uart_data_i, then go to ACK.
    - If the RX FIFO is not full, or rx_pop_i=1 that cycle, push the captured byte.
    - Otherwise set rx_overrun_o=1 and discard the byte.
  - ACK: uart_ack_o=1; stay until uart_read_ready_i=0, then uart_ack_o=0 and go to IDLE.
  - Every byte presented by the core is acknowledged, so the core is never stalled.
  - Latency: a byte is visible at rx_data_o 2 cycles after uart_read_ready_i rises, if the FIFO was empty.
- Overrun flag:
  - rx_overrun_clear_i=1 clears rx_overrun_o next cycle.
  - Set wins over clear in the same cycle.
- Flag timing:
  - tx_full_o and rx_empty_o are registered and reflect occupancy after the cycle's push/pop.
  - tx_full_o: count equals 2^DEPTH_LOG2.
  - rx_empty_o: count equals 0.

Test Plan:
- Push 0x55, 0xA3, 0x0F with busy model (busy high 1 cycle after write, for 20 cycles) -> uart_write_o pulses 3 times, each 1 cycle; uart_data_o=0x55,0xA3,0x0F in order, each stable for its whole busy period; tx_count_o returns to 0.
- Push 17 bytes with DEPTH_LOG2=4, busy held high -> tx_full_o=1 after 16 pushes; 17th ignored; tx_count_o=16; after busy releases, exactly 16 bytes are written.
- Core presents 0x3C with ready high for 5 cycles -> uart_ack_o high from the cycle after ready rises until ready falls; exactly one push; rx_data_o=0x3C, rx_count_o=1.
- Fill RX with 16 bytes, present a 17th (0x99) without pop -> byte acked and dropped, rx_overrun_o=1; RX contents unchanged; rx_overrun_clear_i pulse -> rx_overrun_o=0.
- RX full and core presents 0x77 while rx_pop_i=1 in the same cycle -> 0x77 accepted, count stays 16, no overrun, FIFO order preserved across pointer wrap.
- Assert reset_i during WAIT_IDLE with 3 bytes queued -> next cycle uart_write_o=0, tx_count_o=0, FSMs IDLE; a new push after reset transmits normally.
